axi_lite_pattern_master: RTL

- Synthesisable AXI4-Lite master self-test engine; generalised successor of the fixed 4-word write/read/compare master currently used for Graphics IP bring-up.
- One start pulse → writes NUM_WORDS words at BASE_ADDR + i*STRIDE, reads them back, compares, reports done/error/error-count.
- Sits on the IP's M00 AXI port.
- Four selectable data-pattern modes; single outstanding transaction.

---
 rtl/axi_lite_pattern_master_if.sv | 41 ++++
 rtl/axi_lite_pattern_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pattern_master_if.sv
// AXI4-Lite master/slave bundle used by the pattern self-test engine.
interface axi_lite_pattern_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_pattern_master.sv
// AXI4-Lite self-test master: writes NUM_WORDS patterned words, reads them
// back, compares, and reports done / sticky error / saturating error count.
module axi_lite_pattern_master #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_WORDS  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned           STRIDE     = 4,
  parameter logic [31:0]           SEED       = 32'hA5A5_0001,
  parameter int unsigned           CNT_W      = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             INIT_AXI_TXN,
  input  logic [1:0]       MODE,
  output logic             TXN_DONE,
  output logic             ERROR,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic             BUSY,
  axi_lite_pattern_master_if.master m_axi
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [DATA_WIDTH-1:0] SEED_D   = DATA_WIDTH'(SEED);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_INCR, MODE_WALK, MODE_LFSR, MODE_INV
  } mode_e;

  state_e                state;
  mode_e                 mode_q;
  logic                  init_q;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] pat_q;
  logic                  aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic                  start;
  logic                  last;
  logic [1:0]            err_n;

  function automatic logic [DATA_WIDTH-1:0] first_pattern(input mode_e m);
    case (m)
      MODE_WALK: first_pattern = DATA_WIDTH'(1);
      MODE_INV:  first_pattern = ~SEED_D;
      default:   first_pattern = SEED_D;
    endcase
  endfunction

  // Patterns advance incrementally from the previous word; ~(S+i+1) == ~(S+i)-1.
  function automatic logic [DATA_WIDTH-1:0] next_pattern(input mode_e m,
                                                        input logic [DATA_WIDTH-1:0] p);
    logic [31:0] s;
    s = p[31:0];
    s = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    case (m)
      MODE_INCR: next_pattern = p + DATA_WIDTH'(1);
      MODE_WALK: next_pattern = {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      MODE_LFSR: next_pattern = DATA_WIDTH'({((DATA_WIDTH + 31) / 32){s}});
      default:   next_pattern = p - DATA_WIDTH'(1);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W + 1)'(n);
    sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign start = INIT_AXI_TXN & ~init_q;
  assign last  = (idx == LAST_IDX);

  always_comb begin
    err_n = '0;
    if (state == S_WR_RESP && m_axi.BVALID)
      err_n = 2'(m_axi.BRESP != 2'b00);
    else if (state == S_RD_RESP && m_axi.RVALID)
      err_n = 2'(m_axi.RRESP != 2'b00) + 2'(m_axi.RDATA != pat_q);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      mode_q    <= MODE_INCR;
      init_q    <= 1'b0;
      idx       <= '0;
      addr_q    <= BASE_ADDR;
      pat_q     <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
      TXN_DONE  <= 1'b0;
      ERROR     <= 1'b0;
      ERR_COUNT <= '0;
      BUSY      <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (err_n != 2'd0) begin
        ERROR     <= 1'b1;
        ERR_COUNT <= sat_add(ERR_COUNT, err_n);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q    <= mode_e'(MODE);
            idx       <= '0;
            addr_q    <= BASE_ADDR;
            pat_q     <= first_pattern(mode_e'(MODE));
            ERROR     <= 1'b0;
            ERR_COUNT <= '0;
            TXN_DONE  <= 1'b0;
            BUSY      <= 1'b1;
            aw_valid  <= 1'b1;
            w_valid   <= 1'b1;
            state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (aw_valid && m_axi.AWREADY) aw_valid <= 1'b0;
          if (w_valid && m_axi.WREADY)   w_valid  <= 1'b0;
          if ((!aw_valid || m_axi.AWREADY) && (!w_valid || m_axi.WREADY)) begin
            b_ready <= 1'b1;
            state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi.BVALID) begin
            b_ready <= 1'b0;
            if (last) begin
              idx      <= '0;
              addr_q   <= BASE_ADDR;
              pat_q    <= first_pattern(mode_q);
              ar_valid <= 1'b1;
              state    <= S_RD_REQ;
            end else begin
              idx      <= idx + IDX_W'(1);
              addr_q   <= addr_q + STRIDE_A;
              pat_q    <= next_pattern(mode_q, pat_q);
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (m_axi.ARREADY) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (m_axi.RVALID) begin
            r_ready <= 1'b0;
            if (last) begin
              TXN_DONE <= 1'b1;
              BUSY     <= 1'b0;
              state    <= S_DONE;
            end else begin
              idx      <= idx + IDX_W'(1);
              addr_q   <= addr_q + STRIDE_A;
              pat_q    <= next_pattern(mode_q, pat_q);
              ar_valid <= 1'b1;
              state    <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = '0;
  assign m_axi.AWVALID = aw_valid;
  assign m_axi.WDATA   = pat_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WVALID  = w_valid;
  assign m_axi.BREADY  = b_ready;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = '0;
  assign m_axi.ARVALID = ar_valid;
  assign m_axi.RREADY  = r_ready;

endmodule
